// File: rtl/mux_pipe_skid.sv
// mux_pipe_skid
//   N-input, W-bit select mux with a registered output stage and a 2-entry
//   (output + skid) buffer on a valid/ready handshake. in_ready comes straight
//   from a flop, so it never sees same-cycle out_ready. Out-of-range selects
//   produce a zero beat tagged with out_err and are tallied in a saturating
//   debug counter.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data      packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel       input select
//   in_valid     upstream beat valid
//   in_ready     block can accept a beat (registered)
//   out_data     registered selected data
//   out_err      beat on out_data had an out-of-range select
//   out_valid    output beat valid
//   out_ready    downstream accepts the beat
//   err_cnt      saturating count of accepted out-of-range beats
//   err_cnt_clr  synchronous clear of err_cnt (wins over increment)
//
// State table ({out full, skid full})
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0, in_ready=1
//   ST_ONE   | beat in OUT, skid empty, in_ready=1
//   ST_FULL  | beats in OUT and SKID, in_ready=0
module mux_pipe_skid #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN),
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        err_cnt,
   input  logic                    err_cnt_clr
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sel_data;
   logic             sel_ok;
   logic             accept;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;

   // A select that matches no input leaves sel_data at zero and sel_ok low,
   // which is exactly the out-of-range beat we want to emit.
   always_comb begin
      sel_data = '0;
      sel_ok   = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_data = in_data[k*WIDTH +: WIDTH];
            sel_ok   = 1'b1;
         end
      end
   end

   assign accept = in_valid && in_ready;

   // in_ready and out_valid are registered alongside the state so neither
   // has a combinational path from the handshake inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         out_err   <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (accept) begin
                  out_data  <= sel_data;
                  out_err   <= !sel_ok;
                  out_valid <= 1'b1;
                  state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (out_ready) begin
                  if (accept) begin
                     out_data <= sel_data;
                     out_err  <= !sel_ok;
                  end else begin
                     out_valid <= 1'b0;
                     state     <= ST_EMPTY;
                  end
               end else if (accept) begin
                  // OUT is stalled: park the new beat so OUT stays stable.
                  skid_data <= sel_data;
                  skid_err  <= !sel_ok;
                  in_ready  <= 1'b0;
                  state     <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  out_data <= skid_data;
                  out_err  <= skid_err;
                  in_ready <= 1'b1;
                  state    <= ST_ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (err_cnt_clr) begin
         err_cnt <= '0;
      end else if (accept && !sel_ok && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/mux_pipe_skid.md
Name: mux_pipe_skid

Overview:
- Parametrised N-input, W-bit multiplexer with a registered output stage and a valid/ready handshake on both sides.
- Generalises the fixed 5-bit 2:1 datapath mux in width and input count.
- Adds a 2-entry skid buffer so that `in_ready` does not depend combinationally on `out_ready`.
- Used as the select point between pipeline stages: register-destination select, write-back select, ALU operand select.
- Flags out-of-range selects and counts them for debug.

Parameters:
- WIDTH, 32: data bits per input.
- NUM_IN, 4: number of selectable inputs; must be ≥ 2.
- SEL_W, $clog2(NUM_IN): width of `in_sel`; may be overridden to exceed the minimum.
- CNT_W, 8: width of the saturating select-error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  selects input k.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  registered selected data.
- out_err  output  1  the beat on `out_data` had an out-of-range select.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- err_cnt  output  CNT_W  saturating count of accepted beats with an out-of-range select.
- err_cnt_clr  input  1  synchronous clear of `err_cnt`.

Behaviour:
- Clock and reset: one clock domain (`clk`). `rst_n` is asynchronous and active-low.
- Reset values: `out_valid`=0, `out_data`=0, `out_err`=0, `err_cnt`=0, skid entry empty with its data zeroed. `in_ready`=1 immediately after `rst_n` deasserts.
- Reset mid-operation: asserting `rst_n` mid-transfer drops all held beats with no partial output. Inputs are ignored while `rst_n`=0.
- Accept condition: a beat is accepted when `in_valid` && `in_ready` at a rising edge.
- Select and mux:
  - Selection happens at acceptance.
  - If `in_sel` < NUM_IN: data = input[`in_sel`], err = 0.
  - Otherwise: data = 0, err = 1.
- Storage: output register (OUT) plus one skid register (SKID). The state is the pair {OUT full, SKID full}.
  - EMPTY (0,0): accept → OUT loaded, go to ONE.
  - ONE (1,0):
    - `out_ready` with no accept → EMPTY.
    - `out_ready` with accept → OUT reloaded, stay ONE.
    - No `out_ready` with accept → beat goes to SKID, go to FULL.
    - No `out_ready` with no accept → hold.
  - FULL (1,1):
    - `in_ready`=0.
    - `out_ready` → SKID moves to OUT, go to ONE.
    - Otherwise hold.
  - (0,1) is unreachable.
- `in_ready` = !SKID full. It is driven from a register only; there is no combinational path from `out_ready`.
- Latency: 1 cycle from acceptance to `out_valid` when OUT is empty or draining.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_err` are held stable.
- `err_cnt`:
  - Increments by 1 on each accepted beat whose err=1.
  - Saturates at 2^CNT_W−1 with no wrap.
  - `err_cnt_clr` takes priority: when it coincides with an error accept, the result is 0.
- `out_data` when `out_valid`=0 retains its last value and is don't-care to consumers.

Test Plan:
- Reset and pass-through:
  - Stimulus: assert `rst_n`=0 mid-stream, release; `out_ready`=1; send sel=0..3 with `in_data`={0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}.
  - Required: during reset, `out_valid`=0 and `out_data`=0; after release, `in_ready`=1.
  - Required: `out_data` = 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003, each 1 cycle after acceptance, back-to-back with `out_valid` continuous.
- Backpressure into skid:
  - Stimulus: `out_ready`=0, send 3 beats.
  - Required: beats 1–2 accepted, `in_ready`=0 on the cycle after beat 2, beat 3 stalled, `out_data` stable.
  - Stimulus: release `out_ready`.
  - Required: beats 1, 2, 3 emitted in order, none lost.
- Random valid/ready:
  - Stimulus: 1000 beats, 50% toggling on both handshakes, WIDTH=5, NUM_IN=2.
  - Required: the scoreboard matches every beat in order; `in_ready` never depends on same-cycle `out_ready`.
- Out-of-range select:
  - Stimulus: NUM_IN=3, SEL_W=2, sel=3.
  - Required: `out_data`=0, `out_err`=1, `err_cnt`=1.
  - Stimulus: next beat with sel=1.
  - Required: `out_err`=0.
- Counter saturation and clear:
  - Stimulus: CNT_W=2, send 5 error beats.
  - Required: `err_cnt` = 1, 2, 3, 3, 3.
  - Stimulus: `err_cnt_clr` on the same cycle as an error accept.
  - Required: `err_cnt`=0.
- Reset while FULL:
  - Stimulus: fill OUT and SKID, pulse `rst_n` low asynchronously, away from the clock edge.
  - Required: `out_valid` drops immediately; after release, `in_ready`=1 and no stale beat is emitted.
